fetch_axi_rd_master: RTL and testbench

FETCH_AXI_RD_MASTER -- requirements
Module: fetch_axi_rd_master

---
 rtl/fetch_axi_rd_master_if.sv | 54 +++++
 rtl/fetch_axi_rd_master.sv | 122 ++++++++++++
 tb/tb_fetch_axi_rd_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_axi_rd_master_if.sv
// Line-fetch request, AXI AR/R and instruction-FIFO push signals bundled for fetch_axi_rd_master.
// Latency: n/a (wires only).
// Backpressure: n/a; master = the fetch engine, slave = request source / AXI slave / FIFO side.
// Ports:
//   req_valid_i/req_ready_o/req_addr_i        line-fetch request handshake + start address
//   m_axi_ar*                                 AXI read-address channel
//   m_axi_r*                                  AXI read-data channel
//   wr_en_o/wr_data_o/wr_full_i               66-bit push port into the async instruction FIFO
interface fetch_axi_rd_master_if #(
  parameter int AXI_ADDR_W = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [AXI_ADDR_W-1:0] req_addr_i;

  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [AXI_ADDR_W-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;

  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [63:0]           m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;

  logic                  wr_en_o;
  logic [65:0]           wr_data_o;
  logic                  wr_full_i;

  modport master (
    input  req_valid_i, req_addr_i,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    input  wr_full_i,
    output req_ready_o,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_rready,
    output wr_en_o, wr_data_o
  );

  modport slave (
    output req_valid_i, req_addr_i,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    output wr_full_i,
    input  req_ready_o,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_rready,
    input  wr_en_o, wr_data_o
  );
endinterface

// File: rtl/fetch_axi_rd_master.sv
// Fetches one cache line per request as a single INCR AXI burst and pushes each beat as {err,last,data}.
// Latency: R beat accepted at cycle N appears on wr_en_o/wr_data_o at cycle N+1.
// Backpressure: 2-entry skid buffer; rready drops when it is full, wr_full_i only stalls the pop.
// Ports: axi_clk, axi_resetn (async active-low), bus (fetch_axi_rd_master_if.master).
// Optional macro FETCH_ALIGN_CHK_EN: misaligned line addresses return one error beat instead of a burst.
module fetch_axi_rd_master #(
  parameter int AXI_ADDR_W  = 32,
  parameter int BURST_BEATS = 4
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  fetch_axi_rd_master_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]            r_state, w_state_nxt;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [4:0]            r_beat_cnt;
  logic [65:0]           r_buf [2];
  logic                  r_wr_ptr, r_rd_ptr;
  logic [1:0]            r_cnt, w_cnt_nxt;
  logic                  r_req_rdy;

  logic                  w_req_acc, w_misaligned, w_rready, w_r_acc;
  logic                  w_last_beat, w_burst_end, w_push, w_pop, w_wr_en;
  logic [65:0]           w_push_dat;

  // r_req_rdy is only ever set when the next state is IDLE with an empty skid buffer.
  assign w_req_acc = r_req_rdy & bus.req_valid_i;

`ifdef FETCH_ALIGN_CHK_EN
  localparam int ALIGN_W = $clog2(BURST_BEATS * 8);
  assign w_misaligned = |bus.req_addr_i[ALIGN_W-1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_rready    = (r_state == S_DATA) && (r_cnt != 2'd2);
  assign w_r_acc     = w_rready & bus.m_axi_rvalid;
  assign w_last_beat = (r_beat_cnt == 5'(BURST_BEATS - 1));
  // A burst ends on rlast or on the final expected beat, whichever comes first.
  assign w_burst_end = w_r_acc & (bus.m_axi_rlast | w_last_beat);

  assign w_wr_en = (r_cnt != 2'd0);
  assign w_pop   = w_wr_en & ~bus.wr_full_i;
  // Misaligned request pushes its error beat straight into the (empty) skid buffer.
  assign w_push  = w_r_acc | (w_req_acc & w_misaligned);

  always_comb begin
    w_push_dat = {(bus.m_axi_rresp != 2'b00), (bus.m_axi_rlast | w_last_beat), bus.m_axi_rdata};
    if (w_req_acc && w_misaligned) begin
      w_push_dat = {1'b1, 1'b1, 64'h0};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_acc && !w_misaligned) w_state_nxt = S_ADDR;
      S_ADDR:  if (bus.m_axi_arready) w_state_nxt = S_DATA;
      S_DATA:  if (w_burst_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_cnt - 2'd1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_beat_cnt <= '0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_cnt      <= 2'd0;
      r_req_rdy  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      // Registered so req_ready_o is flop-driven and low throughout reset.
      r_req_rdy <= (w_state_nxt == S_IDLE) && (w_cnt_nxt == 2'd0);
      if (w_req_acc) begin
        r_addr <= bus.req_addr_i & ~AXI_ADDR_W'(7);
      end
      if (w_burst_end) begin
        r_beat_cnt <= '0;
      end else if (w_r_acc) begin
        r_beat_cnt <= r_beat_cnt + 5'd1;
      end
      if (w_push) begin
        r_buf[r_wr_ptr] <= w_push_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  assign bus.req_ready_o   = r_req_rdy;
  assign bus.m_axi_arvalid = (r_state == S_ADDR);
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arlen   = 8'(BURST_BEATS - 1);
  assign bus.m_axi_arsize  = 3'b011;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_rready  = w_rready;
  assign bus.wr_en_o       = w_wr_en;
  assign bus.wr_data_o     = r_buf[r_rd_ptr];

endmodule

// File: tb/tb_fetch_axi_rd_master.sv
// Self-checking bench for fetch_axi_rd_master: per-cycle vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: bench drives wr_full_i directly.
module tb_fetch_axi_rd_master;
  localparam int AW = 32;
  localparam int BB = 4;

  logic axi_clk = 1'b0;
  logic axi_resetn;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  logic [65:0] exp_q [$];

  fetch_axi_rd_master_if #(.AXI_ADDR_W(AW)) bus ();

  fetch_axi_rd_master #(.AXI_ADDR_W(AW), .BURST_BEATS(BB)) dut (
    .axi_clk   (axi_clk),
    .axi_resetn(axi_resetn),
    .bus       (bus)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic        rv;   logic [31:0] addr; logic ar;   logic vl;
    logic [63:0] d;    logic [1:0]  resp; logic last; logic full;
    logic        e_rr; logic e_av; logic [31:0] e_aa; logic e_rdy; logic e_we; logic [65:0] e_wd;
  } vec_t;

  vec_t tbl [27];
  int   nv = 0;

  localparam logic [63:0] D0 = 64'hD0D0_0000_1111_0000, D1 = 64'hD1D1_0000_1111_0001;
  localparam logic [63:0] D2 = 64'hD2D2_0000_1111_0002, D3 = 64'hD3D3_0000_1111_0003;
  localparam logic [63:0] E0 = 64'hE0E0_2222_0000_0000, E1 = 64'hE1E1_2222_0000_0001;
  localparam logic [63:0] E2 = 64'hE2E2_2222_0000_0002, E3 = 64'hE3E3_2222_0000_0003;
  localparam logic [63:0] F0 = 64'hF0F0_3333_0000_0000, F1 = 64'hF1F1_3333_0000_0001;
  localparam logic [63:0] F2 = 64'hF2F2_3333_0000_0002, F3 = 64'hF3F3_3333_0000_0003;
  localparam logic [63:0] F4 = 64'hF4F4_3333_0000_0004;

  task automatic add(input logic rv, input logic [31:0] addr, input logic ar, input logic vl,
                     input logic [63:0] d, input logic [1:0] resp, input logic last, input logic full,
                     input logic e_rr, input logic e_av, input logic [31:0] e_aa, input logic e_rdy,
                     input logic e_we, input logic [65:0] e_wd);
    tbl[nv] = '{rv, addr, ar, vl, d, resp, last, full, e_rr, e_av, e_aa, e_rdy, e_we, e_wd};
    nv++;
  endtask

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid_i   = 1'b0; bus.req_addr_i  = '0;  bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0; bus.m_axi_rdata = '0;  bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0; bus.wr_full_i   = 1'b0;
  endtask

  task automatic wait_rr(input string nm);
    int g;
    g = 0;
    while (!bus.req_ready_o && g < 30) begin
      @(negedge axi_clk); #2; g++;
    end
    chk(nm, 66'(bus.req_ready_o), 66'(1'b1));
  endtask

  // Issue one request, hold arready low for ar_delay cycles, then feed n beats (rlast on last).
  task automatic do_burst(input logic [31:0] addr, input logic [31:0] exp_aa, input int ar_delay,
                          input int n, input logic [63:0] base);
    int g;
    @(negedge axi_clk); #2;
    wait_rr("burst_req_ready");
    bus.req_valid_i = 1'b1; bus.req_addr_i = addr;
    @(negedge axi_clk); bus.req_valid_i = 1'b0; #2;
    for (int c = 0; c <= ar_delay; c++) begin
      chk("ar_valid",  66'(bus.m_axi_arvalid), 66'(1'b1));
      chk("ar_addr",   66'(bus.m_axi_araddr),  66'(exp_aa));
      chk("ar_len",    66'(bus.m_axi_arlen),   66'(8'd3));
      chk("ar_req_rdy", 66'(bus.req_ready_o),  66'(1'b0));
      if (c == ar_delay) bus.m_axi_arready = 1'b1;
      @(negedge axi_clk); bus.m_axi_arready = 1'b0; #2;
    end
    for (int b = 0; b < n; b++) begin
      bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = base + 64'(b);
      bus.m_axi_rresp  = 2'b00; bus.m_axi_rlast = (b == n - 1);
      g = 0;
      while (!bus.m_axi_rready && g < 20) begin
        @(negedge axi_clk); #2; g++;
      end
      chk("beat_rready", 66'(bus.m_axi_rready), 66'(1'b1));
      exp_q.push_back({1'b0, (b == n - 1), base + 64'(b)});
      @(negedge axi_clk); #2;
    end
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
    wait_rr("burst_done_rr");
    chk("burst_q_empty", 66'(exp_q.size()), 66'd0);
  endtask

  // Scoreboard for the hand-written sequences: every pop must match the next expected entry.
  always begin : mon
    logic [65:0] e;
    @(negedge axi_clk); #4;
    if (mon_en && axi_resetn && bus.wr_en_o && !bus.wr_full_i) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL push_unexpected act=%h exp=none", bus.wr_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("push_data", bus.wr_data_o, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    axi_resetn = 1'b0;
    drive_idle();

    // Basic 4-beat burst at 0x1000.
    add(1'b1, 32'h1000, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 66'h0);
    add(1'b0, 32'h0,    1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0,  1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 66'h0);
    add(1'b0, 32'h0,    1'b0, 1'b1, D0,    2'b00, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 66'h0);
    add(1'b0, 32'h0,    1'b0, 1'b1, D1,    2'b00, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b1, 1'b1, {2'b00, D0});
    add(1'b0, 32'h0,    1'b0, 1'b1, D2,    2'b00, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b1, 1'b1, {2'b00, D1});
    add(1'b0, 32'h0,    1'b0, 1'b1, D3,    2'b00, 1'b1, 1'b0,  1'b0, 1'b0, 32'h0,    1'b1, 1'b1, {2'b00, D2});
    add(1'b0, 32'h0,    1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, {2'b01, D3});
    add(1'b0, 32'h0,    1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 66'h0);
    // FIFO full for the first beats, beat 2 carries SLVERR.
    add(1'b1, 32'h2000, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b1,  1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 66'h0);
    add(1'b0, 32'h0,    1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 1'b1,  1'b0, 1'b1, 32'h2000, 1'b0, 1'b0, 66'h0);
    add(1'b0, 32'h0,    1'b0, 1'b1, E0,    2'b00, 1'b0, 1'b1,  1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 66'h0);
    add(1'b0, 32'h0,    1'b0, 1'b1, E1,    2'b00, 1'b0, 1'b1,  1'b0, 1'b0, 32'h0,    1'b1, 1'b1, {2'b00, E0});
    add(1'b0, 32'h0,    1'b0, 1'b1, E2,    2'b10, 1'b0, 1'b1,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, {2'b00, E0});
    add(1'b0, 32'h0,    1'b0, 1'b1, E2,    2'b10, 1'b0, 1'b1,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, {2'b00, E0});
    add(1'b0, 32'h0,    1'b0, 1'b1, E2,    2'b10, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, {2'b00, E0});
    add(1'b0, 32'h0,    1'b0, 1'b1, E2,    2'b10, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b1, 1'b1, {2'b00, E1});
    add(1'b0, 32'h0,    1'b0, 1'b1, E3,    2'b00, 1'b1, 1'b0,  1'b0, 1'b0, 32'h0,    1'b1, 1'b1, {2'b10, E2});
    add(1'b0, 32'h0,    1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, {2'b01, E3});
    add(1'b0, 32'h0,    1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 66'h0);
    // No rlast: final beat gets last forced, a stray fifth beat is refused.
    add(1'b1, 32'h3000, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 66'h0);
    add(1'b0, 32'h0,    1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0,  1'b0, 1'b1, 32'h3000, 1'b0, 1'b0, 66'h0);
    add(1'b0, 32'h0,    1'b0, 1'b1, F0,    2'b00, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 66'h0);
    add(1'b0, 32'h0,    1'b0, 1'b1, F1,    2'b00, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b1, 1'b1, {2'b00, F0});
    add(1'b0, 32'h0,    1'b0, 1'b1, F2,    2'b00, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b1, 1'b1, {2'b00, F1});
    add(1'b0, 32'h0,    1'b0, 1'b1, F3,    2'b00, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b1, 1'b1, {2'b00, F2});
    add(1'b0, 32'h0,    1'b0, 1'b1, F4,    2'b00, 1'b0, 1'b0,  1'b0, 1'b0, 32'h0,    1'b0, 1'b1, {2'b01, F3});
    add(1'b0, 32'h0,    1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 66'h0);

    // Reset state.
    #3;
    chk("rst_req_ready", 66'(bus.req_ready_o),   66'(1'b0));
    chk("rst_arvalid",   66'(bus.m_axi_arvalid), 66'(1'b0));
    chk("rst_araddr",    66'(bus.m_axi_araddr),  66'd0);
    chk("rst_rready",    66'(bus.m_axi_rready),  66'(1'b0));
    chk("rst_wr_en",     66'(bus.wr_en_o),       66'(1'b0));
    chk("rst_wr_data",   bus.wr_data_o,          66'd0);
    repeat (2) @(negedge axi_clk);
    axi_resetn = 1'b1; #2;
    chk("rel_rr_low", 66'(bus.req_ready_o), 66'(1'b0));

    for (int i = 0; i < nv; i++) begin
      @(negedge axi_clk);
      bus.req_valid_i   = tbl[i].rv;   bus.req_addr_i  = tbl[i].addr; bus.m_axi_arready = tbl[i].ar;
      bus.m_axi_rvalid  = tbl[i].vl;   bus.m_axi_rdata = tbl[i].d;    bus.m_axi_rresp   = tbl[i].resp;
      bus.m_axi_rlast   = tbl[i].last; bus.wr_full_i   = tbl[i].full;
      #2;
      chk($sformatf("row%0d_req_ready", i), 66'(bus.req_ready_o),   66'(tbl[i].e_rr));
      chk($sformatf("row%0d_arvalid", i),   66'(bus.m_axi_arvalid), 66'(tbl[i].e_av));
      chk($sformatf("row%0d_rready", i),    66'(bus.m_axi_rready),  66'(tbl[i].e_rdy));
      chk($sformatf("row%0d_wr_en", i),     66'(bus.wr_en_o),       66'(tbl[i].e_we));
      if (tbl[i].e_av) begin
        chk($sformatf("row%0d_araddr", i),  66'(bus.m_axi_araddr),  66'(tbl[i].e_aa));
        chk($sformatf("row%0d_arlen", i),   66'(bus.m_axi_arlen),   66'(8'd3));
        chk($sformatf("row%0d_arsize", i),  66'(bus.m_axi_arsize),  66'(3'b011));
        chk($sformatf("row%0d_arburst", i), 66'(bus.m_axi_arburst), 66'(2'b01));
      end
      if (tbl[i].e_we) begin
        chk($sformatf("row%0d_wr_data", i), bus.wr_data_o, tbl[i].e_wd);
      end
    end

    @(negedge axi_clk);
    drive_idle();
    mon_en = 1'b1;

    // arready held off 5 cycles: payload must stay put.
    do_burst(32'h4000, 32'h4000, 5, BB, 64'hC0DE_0000_0000_0040);

    // Reset after the first beat of a burst, with the FIFO full so nothing drains.
    @(negedge axi_clk);
    bus.wr_full_i = 1'b1; bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h5000;
    @(negedge axi_clk);
    bus.req_valid_i = 1'b0; bus.m_axi_arready = 1'b1;
    @(negedge axi_clk);
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 64'h5555_0000_0000_0000;
    @(negedge axi_clk);
    bus.m_axi_rdata = 64'h5555_0000_0000_0001; #2;
    chk("mid_pre_wr_en", 66'(bus.wr_en_o), 66'(1'b1));
    axi_resetn = 1'b0; #1;
    chk("mid_rst_req_ready", 66'(bus.req_ready_o),   66'(1'b0));
    chk("mid_rst_arvalid",   66'(bus.m_axi_arvalid), 66'(1'b0));
    chk("mid_rst_araddr",    66'(bus.m_axi_araddr),  66'd0);
    chk("mid_rst_rready",    66'(bus.m_axi_rready),  66'(1'b0));
    chk("mid_rst_wr_en",     66'(bus.wr_en_o),       66'(1'b0));
    chk("mid_rst_wr_data",   bus.wr_data_o,          66'd0);
    drive_idle();
    @(negedge axi_clk);
    axi_resetn = 1'b1; #2;
    chk("mid_rel_rr_low", 66'(bus.req_ready_o), 66'(1'b0));
    chk("mid_rel_wr_en",  66'(bus.wr_en_o),     66'(1'b0));
    @(negedge axi_clk); #2;
    chk("mid_rel_rr_high", 66'(bus.req_ready_o), 66'(1'b1));
    chk("mid_rel_wr_en2",  66'(bus.wr_en_o),     66'(1'b0));
    do_burst(32'h6000, 32'h6000, 0, BB, 64'h6666_0000_0000_0000);

`ifdef FETCH_ALIGN_CHK_EN
    // Misaligned request: no AR, a single error beat.
    @(negedge axi_clk); #2;
    wait_rr("align_rr");
    bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h1008;
    exp_q.push_back(66'h3_0000_0000_0000_0000);
    @(negedge axi_clk);
    bus.req_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("align_no_arvalid", 66'(bus.m_axi_arvalid), 66'(1'b0));
      @(negedge axi_clk);
    end
    #2;
    wait_rr("align_done_rr");
    chk("align_q_empty", 66'(exp_q.size()), 66'd0);
`else
    // Low 3 address bits are dropped.
    do_burst(32'h100D, 32'h1008, 0, BB, 64'h7777_0000_0000_0000);
`endif

    repeat (3) @(negedge axi_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
